// File: rtl/serial_rx_port.sv
// serial_rx_port: 8-bit asynchronous serial receiver with 2-flop input sync and sticky error flags.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module serial_rx_port #(
  parameter int BIT_TICKS = 16
) (
  input  logic       CLK,
  input  logic       nCLR,
  input  logic       serial_in,
  input  logic       acknowledge,
  output logic [7:0] data,
  output logic       ready,
  output logic       overrun,
  output logic       frame_err
);
  localparam int CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TICKS / 2 - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [1:0]    sync_q;
  logic          rx;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          good_frame;
`ifdef SERIAL_RX_PARITY_EN
  logic          parity_ok;
`endif

  assign rx      = sync_q[1];
  assign bit_end = (cnt == BIT_LAST);

`ifdef SERIAL_RX_PARITY_EN
  assign good_frame = rx & parity_ok;
`else
  assign good_frame = rx;
`endif

  // Sync flops reset high so a released reset never looks like a start bit by itself.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], serial_in};
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_ok <= 1'b0;
`endif
    end else begin
      // Acknowledge clears first; a completing frame below overrides in the same cycle.
      if (acknowledge) begin
        ready     <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {rx, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            cnt       <= '0;
            parity_ok <= ~(^shreg ^ rx);
            state     <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`else
        ST_PARITY: state <= ST_IDLE;
`endif
        ST_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (good_frame) begin
              data  <= shreg;
              ready <= 1'b1;
              if (ready && !acknowledge) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
